// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the block memory.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              blank;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              host_valid;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [7:0]        starve_events;

    modport slave (
        input  blank, disp_req, disp_addr, host_valid, host_addr, host_data, mem_rdata,
        output disp_ack, disp_rdata, disp_rvalid, host_ready,
               mem_en, mem_we, mem_addr, mem_wdata, starve_events
    );

    modport master (
        output blank, disp_req, disp_addr, host_valid, host_addr, host_data, mem_rdata,
        input  disp_ack, disp_rdata, disp_rvalid, host_ready,
               mem_en, mem_we, mem_addr, mem_wdata, starve_events
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port video memory between display reads and FIFO-buffered host writes.
// Display ack-to-rvalid latency is 2 cycles; host_ready drops only when the write FIFO is full.
module vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic           clk,
    input  logic           rst,
    vram_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    wr_ent_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [CNT_W-1:0]  starve_cnt;
    logic              rd_pend;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [7:0]        events_q;

    logic    fifo_ne;
    logic    fifo_full;
    logic    starved;
    logic    push;
    logic    host_gnt;
    logic    disp_gnt;
    logic    forced;
    wr_ent_t head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_ne   = (wr_ptr != rd_ptr);
    assign fifo_full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign starved   = (starve_cnt >= CNT_W'(STARVE_LIMIT));
    assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign push      = bus.host_valid && bus.host_ready;

    always_comb begin
        host_gnt = 1'b0;
        disp_gnt = 1'b0;
        forced   = 1'b0;
        if (!rst) begin
            if (fifo_ne && (!bus.disp_req || bus.blank || starved)) begin
                host_gnt = 1'b1;
                forced   = bus.disp_req && !bus.blank;
            end else if (bus.disp_req) begin
                disp_gnt = 1'b1;
            end
        end
    end

    assign bus.host_ready    = !rst && !fifo_full;
    assign bus.disp_ack      = disp_gnt;
    assign bus.mem_en        = host_gnt || disp_gnt;
    assign bus.mem_we        = host_gnt;
    assign bus.mem_addr      = host_gnt ? head.addr : bus.disp_addr;
    assign bus.mem_wdata     = head.data;
    assign bus.disp_rvalid   = rvalid_q;
    assign bus.disp_rdata    = rdata_q;
    assign bus.starve_events = events_q;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= wr_ent_t'{bus.host_addr, bus.host_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            events_q   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (host_gnt)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);

            if (!fifo_ne || host_gnt)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + CNT_W'(1);

            if (forced && (events_q != 8'hFF))
                events_q <= events_q + 8'd1;

            // Memory returns data the cycle after the grant; register it once more.
            rd_pend  <= disp_gnt;
            rvalid_q <= rd_pend;
            if (rd_pend)
                rdata_q <= bus.mem_rdata;
        end
    end
endmodule
